// File: rtl/mem_stage.sv
// RV32I memory-access stage: ALU pass-through, loads/stores over req/gnt/rvalid, load sizing and extension.
// Latency: 1 cycle for non-memory ops and faults, at least 2 cycles for stores, at least 3 for loads.
// Backpressure: in_ready drops while a memory transaction is outstanding; write-back never stalls.
module mem_stage #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_store_data,
   input  logic [2:0]  in_funct3,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic [4:0]  in_rd,
   input  logic        in_reg_write,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        out_err
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   // Last count value before a stalled wait is abandoned.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  funct3_q;
   logic        we_q;
   logic [4:0]  rd_q;
   logic        reg_write_q;
   logic [15:0] cnt;
   logic [31:0] load_val;
   logic [31:0] rdata_shift;
   logic        req_we;

   // Size/alignment legality of an incoming memory op; BU/HU exist only for loads.
   function automatic logic access_ok(input logic [2:0] f3, input logic wr, input logic [1:0] a);
      logic ok;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = ~a[0];
         3'b010:  ok = (a == 2'b00);
         3'b100:  ok = ~wr;
         3'b101:  ok = ~wr & ~a[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign in_ready  = (state == IDLE);
   assign dmem_req  = (state == REQ);
   assign req_we    = dmem_req & we_q;
   assign dmem_we   = req_we;
   assign dmem_addr = dmem_req ? {addr_q[31:2], 2'b00} : 32'h0;

   // Byte enables and lane-replicated store data, only while a store request is up.
   always_comb begin
      dmem_wstrb = 4'b0000;
      dmem_wdata = 32'h0;
      if (req_we) begin
         case (funct3_q[1:0])
            2'b00: begin
               dmem_wstrb = 4'b0001 << addr_q[1:0];
               dmem_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
               dmem_wstrb = 4'b0011 << addr_q[1:0];
               dmem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
               dmem_wstrb = 4'b1111;
               dmem_wdata = wdata_q;
            end
         endcase
      end
   end

   // Pick the addressed byte/half out of the returned word and extend it.
   always_comb begin
      rdata_shift = dmem_rdata >> {addr_q[1:0], 3'b000};
      case (funct3_q)
         3'b000:  load_val = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
         3'b001:  load_val = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
         3'b100:  load_val = {24'h0, rdata_shift[7:0]};
         3'b101:  load_val = {16'h0, rdata_shift[15:0]};
         default: load_val = dmem_rdata;
      endcase
   end

   // Control FSM, latched request and registered write-back outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         funct3_q      <= 3'b000;
         we_q          <= 1'b0;
         rd_q          <= 5'd0;
         reg_write_q   <= 1'b0;
         cnt           <= 16'd0;
         out_valid     <= 1'b0;
         out_data      <= 32'h0;
         out_rd        <= 5'd0;
         out_reg_write <= 1'b0;
         out_err       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  addr_q      <= in_alu_result;
                  wdata_q     <= in_store_data;
                  funct3_q    <= in_funct3;
                  we_q        <= in_mem_write;
                  rd_q        <= in_rd;
                  reg_write_q <= in_reg_write;
                  cnt         <= 16'd0;
                  out_rd      <= in_rd;
                  out_data    <= in_alu_result;
                  if (!in_mem_read && !in_mem_write) begin
                     out_valid     <= 1'b1;
                     out_reg_write <= in_reg_write;
                  end else if (!access_ok(in_funct3, in_mem_write, in_alu_result[1:0])) begin
                     // Faulting access never reaches memory; report the address.
                     out_valid     <= 1'b1;
                     out_err       <= 1'b1;
                     out_reg_write <= 1'b0;
                  end else begin
                     state <= REQ;
                  end
               end
            end
            REQ: begin
               if (dmem_gnt) begin
                  cnt <= 16'd0;
                  if (we_q) begin
                     out_valid     <= 1'b1;
                     out_data      <= addr_q;
                     out_rd        <= rd_q;
                     out_reg_write <= 1'b0;
                     state         <= IDLE;
                  end else begin
                     state <= RESP;
                  end
               end else if (cnt == CNT_LAST) begin
                  out_valid     <= 1'b1;
                  out_err       <= 1'b1;
                  out_data      <= addr_q;
                  out_rd        <= rd_q;
                  out_reg_write <= 1'b0;
                  state         <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP: begin
               if (dmem_rvalid) begin
                  out_valid     <= 1'b1;
                  out_data      <= load_val;
                  out_rd        <= rd_q;
                  out_reg_write <= reg_write_q;
                  state         <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  out_valid     <= 1'b1;
                  out_err       <= 1'b1;
                  out_data      <= addr_q;
                  out_rd        <= rd_q;
                  out_reg_write <= 1'b0;
                  state         <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam int TMO = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_alu_result;
   logic [31:0] in_store_data;
   logic [2:0]  in_funct3;
   logic        in_mem_read;
   logic        in_mem_write;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        out_valid;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_err;

   mem_stage #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_result(in_alu_result), .in_store_data(in_store_data),
      .in_funct3(in_funct3), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_rd(in_rd), .in_reg_write(in_reg_write),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_err(out_err)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        rw;
      logic [4:0]  rd;
      bit          chk_data;
      bit          chk_rd;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Access size in bytes for a funct3 code, 0 when the code is not a valid access.
   function automatic int model_size(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic bit model_legal(input logic [2:0] f3, input bit wr, input logic [31:0] a);
      int sz = model_size(f3);
      if (sz == 0) return 1'b0;
      if (wr && f3 >= 3'd4) return 1'b0;
      return (a % sz) == 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      int     sz  = model_size(f3);
      longint v   = longint'(w) >> (8 * (a % 4));
      longint lim = longint'(1) << (8 * sz);
      if (sz == 4) return w;
      v = v % lim;
      if (f3 < 3'd4 && v >= lim / 2) v = v - lim;
      return 32'(v);
   endfunction

   function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
      int sz = model_size(f3);
      return 4'(((1 << sz) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      int sz = model_size(f3);
      if (sz == 1) return (d % 256) * 32'h0101_0101;
      if (sz == 2) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   // Monitor: every write-back pulse must match the oldest expected result, on the expected cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got data 0x%08h err %0b, expected no output (cycle %0d)",
                     out_data, out_err, cyc);
         end else begin
            e = exp_q.pop_front();
            check("out_cycle", 32'(cyc), 32'(e.cyc));
            check("out_err", {31'd0, out_err}, {31'd0, e.err});
            check("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
            if (e.chk_data) check("out_data", out_data, e.data);
            if (e.chk_rd)   check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
         end
      end
   end

   // Issue one instruction from IDLE and play the memory side with the given delays.
   // g: REQ cycles before gnt; r: RESP cycles before rvalid; no_gnt/no_rv: memory never answers.
   task automatic issue(input bit rd_op, input bit wr_op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input bit rw, input int g, input int r,
                        input logic [31:0] rdata, input bit no_gnt, input bit no_rv);
      exp_t e;
      bit   mem   = rd_op | wr_op;
      bit   legal = model_legal(f3, wr_op, addr);
      int   c     = cyc;
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid      = 1'b1;
      in_mem_read   = rd_op;
      in_mem_write  = wr_op;
      in_funct3     = f3;
      in_alu_result = addr;
      in_store_data = sdata;
      in_rd         = rd;
      in_reg_write  = rw;
      e.rd = rd; e.chk_rd = 1'b0; e.chk_data = 1'b1; e.data = addr; e.err = 1'b0; e.rw = 1'b0;
      if (!mem) begin
         e.rw = rw; e.chk_rd = 1'b1; e.cyc = c + 1;
      end else if (!legal) begin
         e.err = 1'b1; e.cyc = c + 1;
      end else if (no_gnt) begin
         e.err = 1'b1; e.chk_data = 1'b0; e.cyc = c + 1 + TMO;
      end else if (wr_op) begin
         e.cyc = c + 2 + g;
      end else if (no_rv) begin
         e.err = 1'b1; e.chk_data = 1'b0; e.cyc = c + 2 + g + TMO;
      end else begin
         e.data = model_load(f3, addr, rdata); e.rw = rw; e.chk_rd = 1'b1; e.cyc = c + 3 + g + r;
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!mem) return;
      if (!legal) begin
         check("no_req_on_fault", {31'd0, dmem_req}, 32'd0);
         return;
      end
      check("dmem_req", {31'd0, dmem_req}, 32'd1);
      check("dmem_we", {31'd0, dmem_we}, {31'd0, wr_op});
      check("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check("dmem_wstrb", {28'd0, dmem_wstrb}, wr_op ? {28'd0, model_strb(f3, addr)} : 32'd0);
      if (wr_op) check("dmem_wdata", dmem_wdata, model_wdata(f3, sdata));
      if (no_gnt) begin
         repeat (TMO) begin @(posedge clk); #1; end
         check("in_ready_after_timeout", {31'd0, in_ready}, 32'd1);
         check("req_drop_after_timeout", {31'd0, dmem_req}, 32'd0);
         return;
      end
      repeat (g) begin @(posedge clk); #1; end
      if (g > 0) check("dmem_addr_held", dmem_addr, addr & 32'hFFFF_FFFC);
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      if (wr_op) return;
      check("req_drop_after_gnt", {31'd0, dmem_req}, 32'd0);
      check("in_ready_in_resp", {31'd0, in_ready}, 32'd0);
      if (no_rv) begin
         repeat (TMO) begin @(posedge clk); #1; end
         return;
      end
      repeat (r) begin @(posedge clk); #1; end
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_alu_result = '0; in_store_data = '0; in_funct3 = '0;
      in_mem_read = 1'b0; in_mem_write = 1'b0; in_rd = '0; in_reg_write = 1'b0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("rst_dmem_wstrb", {28'd0, dmem_wstrb}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back ALU pass-through.
      issue(0, 0, 3'd0, 32'h11, 32'h0, 5'd1, 1, 0, 0, 32'h0, 0, 0);
      issue(0, 0, 3'd0, 32'h22, 32'h0, 5'd2, 1, 0, 0, 32'h0, 0, 0);
      issue(0, 0, 3'd0, 32'h33, 32'h0, 5'd3, 1, 0, 0, 32'h0, 0, 0);
      check("in_ready_after_passthrough", {31'd0, in_ready}, 32'd1);

      // Directed memory cases.
      issue(0, 1, 3'd0, 32'h1003, 32'hA5, 5'd4, 1, 2, 0, 32'h0, 0, 0);
      issue(1, 0, 3'd0, 32'h2001, 32'h0, 5'd5, 1, 0, 0, 32'h0000_8000, 0, 0);
      issue(1, 0, 3'd4, 32'h2001, 32'h0, 5'd6, 1, 1, 1, 32'h0000_8000, 0, 0);
      issue(1, 0, 3'd1, 32'h2002, 32'h0, 5'd7, 1, 0, 2, 32'h8001_0000, 0, 0);
      issue(1, 0, 3'd2, 32'h3002, 32'h0, 5'd8, 1, 0, 0, 32'h0, 0, 0);
      issue(1, 0, 3'd3, 32'h3000, 32'h0, 5'd9, 1, 0, 0, 32'h0, 0, 0);
      issue(0, 1, 3'd4, 32'h3000, 32'h12, 5'd9, 1, 0, 0, 32'h0, 0, 0);
      issue(0, 1, 3'd1, 32'h3006, 32'hBEEF, 5'd9, 1, 1, 0, 32'h0, 0, 0);
      issue(1, 0, 3'd0, 32'h5000, 32'h0, 5'd10, 1, 0, 0, 32'h0, 1, 0);
      issue(1, 0, 3'd2, 32'h5004, 32'h0, 5'd11, 1, 0, 0, 32'h0, 0, 1);
      // gnt and rvalid on the last waiting cycle win over the timeout.
      issue(1, 0, 3'd5, 32'h6002, 32'h0, 5'd12, 1, TMO - 1, TMO - 1, 32'hCAFE_F00D, 0, 0);
      issue(0, 1, 3'd2, 32'h6008, 32'h1234_5678, 5'd13, 0, TMO - 1, 0, 32'h0, 0, 0);

      // Randomised mix against the reference model.
      for (int i = 0; i < 150; i++) begin
         int kind = $urandom_range(0, 2);
         int tmo  = $urandom_range(0, 15);
         issue(kind == 1, kind == 2, 3'($urandom_range(0, 7)),
               {$urandom_range(0, 65535), 2'($urandom_range(0, 3))} & 32'h0003_FFFF,
               $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), $urandom(),
               tmo == 0, tmo == 1);
      end

      // Reset while waiting in RESP: result discarded, late rvalid ignored.
      in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'd2;
      in_alu_result = 32'h4000; in_rd = 5'd20; in_reg_write = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      @(posedge clk); #1;
      check("resp_in_ready_low", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      check("late_rvalid_out_valid", {31'd0, out_valid}, 32'd0);
      check("late_rvalid_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (5) begin @(posedge clk); #1; end

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- RV32I memory-access stage, directly downstream of the execute stage.
- Consumes the ALU result (effective address or plain result), the store operand and the control bits.
- Performs loads and stores over a req/gnt/rvalid data-memory handshake, sizes and sign-extends load data, and hands a registered result to write-back.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- TIMEOUT, 255, number of cycles waited in REQ or RESP before the transaction is aborted with an error (range 1..65535).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  an EX result is presented
- in_ready  out  1  stage can accept; combinational, equals (state==IDLE)
- in_alu_result  in  32  ALU result; used as the byte address for memory ops
- in_store_data  in  32  rs2 value for stores
- in_funct3  in  3  access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- in_mem_read  in  1  load
- in_mem_write  in  1  store (mem_read and mem_write are never both 1)
- in_rd  in  5  destination register
- in_reg_write  in  1  write-back enable from decode
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_wstrb  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- out_valid  out  1  one-cycle result pulse to WB
- out_data  out  32  write-back value
- out_rd  out  5  destination register
- out_reg_write  out  1  WB enable; forced 0 on error and on stores
- out_err  out  1  misaligned, illegal funct3, or timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, except in_ready=1 once in IDLE; timeout counter=0.
- States: IDLE, REQ, RESP.
- IDLE, in_valid with neither mem_read nor mem_write:
  - Next edge: out_valid=1, out_data=in_alu_result, out_rd/out_reg_write copied.
  - Throughput is 1 per cycle; latency is 1.
- IDLE, in_valid with a memory op:
  - Latch all inputs.
  - Misaligned access (H with addr[0]=1; W with addr[1:0]!=0) or illegal funct3 (011, 110, 111; and 100/101 for stores): stay in IDLE; next edge out_valid=1, out_err=1, out_reg_write=0, out_data=address. No dmem request is issued.
  - Otherwise: go to REQ.
- REQ:
  - dmem_req=1, driven from registers.
  - dmem_wstrb: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b0000.
  - dmem_wdata: SB {4{d[7:0]}}; SH {2{d[15:0]}}; SW d.
  - Request fields are held stable until gnt.
  - On gnt with a store: next edge out_valid=1, out_reg_write=0, out_data=address; go to IDLE.
  - On gnt with a load: go to RESP; dmem_req drops next cycle.
- RESP:
  - Wait for rvalid. rvalid in the same cycle as gnt is not legal; the memory must respond at least 1 cycle after gnt.
  - On rvalid: select the byte/half at addr[1:0]; sign-extend for B/H, zero-extend for BU/HU.
  - Next edge: out_valid=1 with the extracted data and the latched rd/reg_write; go to IDLE.
- Latency: load is ≥3 cycles from acceptance; store is ≥2 cycles.
- Timeout:
  - Counter clears on entry to REQ and RESP and increments each cycle while waiting.
  - When it reaches TIMEOUT without gnt/rvalid: out_valid=1, out_err=1, out_reg_write=0; go to IDLE.
  - gnt/rvalid arriving in the same cycle as the timeout takes priority over the timeout.
- in_ready=0 in REQ and RESP; upstream holds its inputs and in_valid.
- out_valid is high exactly one cycle per accepted instruction. WB never back-pressures.
- Reset mid-transaction: immediately go to IDLE, dmem_req=0, and the outstanding result is discarded. A late rvalid is ignored in IDLE.

Test Plan:
- ALU pass-through: 3 back-to-back non-memory ops 0x11, 0x22, 0x33 → out_valid on 3 consecutive cycles with the same data; in_ready stays 1.
- SB to 0x1003, data 0xA5 → dmem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5; gnt after 2 cycles → out_valid with out_reg_write=0.
- LB at 0x2001, rdata=0x0000_8000 → out_data=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x2002, rdata=0x8001_0000 → 0xFFFF8001.
- LW at 0x3002 → no dmem_req, out_valid=1, out_err=1, out_reg_write=0, one cycle after acceptance.
- TIMEOUT=4, load with gnt never asserted → out_err pulse 4 cycles after entering REQ; in_ready returns to 1.
- rst_n low while in RESP → dmem_req=0, state IDLE, no out_valid; a subsequent rvalid produces no output.
